ctrl_pipe_hazard: RTL

- Holds the ID/EX, EX/MEM and MEM/WB control-field pipeline registers.
- Produces the EX/MEM/WB register addresses and control bits that the forwarding unit consumes.
- Detects the hazards that forwarding cannot cover, and drives PC/IF-ID stall, IF-ID flush and bubble insertion.
- Sits between decode and the forwarding unit; the datapath pipeline registers follow its stall/bubble outputs.

---
 rtl/ctrl_pipe_hazard_if.sv | 25 ++
 rtl/ctrl_pipe_hazard.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_hazard_if.sv
// rtl/ctrl_pipe_hazard_if.sv - decode-stage control bus feeding the pipeline hazard block
interface ctrl_pipe_hazard_if;
  logic [2:0] ID_JumpBranch;
  logic [4:0] ID_rsAddr;
  logic [4:0] ID_rtAddr;
  logic [4:0] ID_wrAddr;
  logic       ID_UseRs;
  logic       ID_UseRt;
  logic       ID_RegWrite;
  logic       ID_MemWrite;
  logic       ID_MemtoReg;
  logic       ID_Taken;

  // decode drives the bus
  modport master (
    output ID_JumpBranch, ID_rsAddr, ID_rtAddr, ID_wrAddr,
    output ID_UseRs, ID_UseRt, ID_RegWrite, ID_MemWrite, ID_MemtoReg, ID_Taken
  );

  // hazard/pipeline block consumes the bus
  modport slave (
    input ID_JumpBranch, ID_rsAddr, ID_rtAddr, ID_wrAddr,
    input ID_UseRs, ID_UseRt, ID_RegWrite, ID_MemWrite, ID_MemtoReg, ID_Taken
  );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// rtl/ctrl_pipe_hazard.sv - control-field pipeline registers with stall/flush/bubble hazard control
module ctrl_pipe_hazard #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_stall,
  ctrl_pipe_hazard_if.slave id,
  output logic [4:0]       EX_rsAddr,
  output logic [4:0]       EX_rtAddr,
  output logic [4:0]       EX_wrAddr,
  output logic             EX_RegWrite,
  output logic             EX_MemWrite,
  output logic             EX_MemtoReg,
  output logic [2:0]       EX_JumpBranch,
  output logic [4:0]       MEM_rtAddr,
  output logic [4:0]       MEM_wrAddr,
  output logic             MEM_RegWrite,
  output logic             MEM_MemWrite,
  output logic             MEM_MemtoReg,
  output logic [2:0]       MEM_JumpBranch,
  output logic [4:0]       WB_wrAddr,
  output logic             WB_RegWrite,
  output logic             WB_MemtoReg,
  output logic             PC_Stall,
  output logic             IFID_Stall,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] JB_BEQ = 3'd1;
  localparam logic [2:0] JB_BNE = 3'd2;
  localparam logic [2:0] JB_JR  = 3'd3;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic id_is_br;
  logic ex_hits_src;
  logic mem_hits_src;
  logic load_use;
  logic br_vs_ex;
  logic br_vs_mem;
  logic hz;

  // Hazard detection; register 0 never matches, WB is covered by the split-cycle register file
  always_comb begin
    id_is_br     = 1'b0;
    ex_hits_src  = 1'b0;
    mem_hits_src = 1'b0;
    load_use     = 1'b0;
    br_vs_ex     = 1'b0;
    br_vs_mem    = 1'b0;
    hz           = 1'b0;

    id_is_br = (id.ID_JumpBranch == JB_BEQ) || (id.ID_JumpBranch == JB_BNE) ||
               (id.ID_JumpBranch == JB_JR);

    ex_hits_src  = (EX_wrAddr != 5'd0) &&
                   ((id.ID_UseRs && (EX_wrAddr == id.ID_rsAddr)) ||
                    (id.ID_UseRt && (EX_wrAddr == id.ID_rtAddr)));
    mem_hits_src = (MEM_wrAddr != 5'd0) &&
                   ((id.ID_UseRs && (MEM_wrAddr == id.ID_rsAddr)) ||
                    (id.ID_UseRt && (MEM_wrAddr == id.ID_rtAddr)));

    // a store's data register loaded by the previous lw is forwarded WB->MEM, so it is exempt
    load_use = EX_MemtoReg && (EX_wrAddr != 5'd0) &&
               ((id.ID_UseRs && (EX_wrAddr == id.ID_rsAddr)) ||
                (id.ID_UseRt && (EX_wrAddr == id.ID_rtAddr) && !id.ID_MemWrite));
    br_vs_ex  = id_is_br && EX_RegWrite && ex_hits_src;
    br_vs_mem = id_is_br && MEM_MemtoReg && mem_hits_src;

    hz = load_use || br_vs_ex || br_vs_mem;
  end

  // Stall/flush/bubble steering, ordered rst > ext_stall > hz > ID_Taken
  always_comb begin
    PC_Stall    = 1'b0;
    IFID_Stall  = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    if (!rst) begin
      PC_Stall    = ext_stall || hz;
      IFID_Stall  = ext_stall || hz;
      IDEX_Bubble = !ext_stall && hz;
      // the taken flag is not trusted while the branch waits on its operands
      IFID_Flush  = !ext_stall && !hz && id.ID_Taken;
    end
  end

  // ID/EX stage: hold on ext_stall, load a bubble on a hazard, otherwise take decode fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      EX_rsAddr     <= 5'd0;
      EX_rtAddr     <= 5'd0;
      EX_wrAddr     <= 5'd0;
      EX_RegWrite   <= 1'b0;
      EX_MemWrite   <= 1'b0;
      EX_MemtoReg   <= 1'b0;
      EX_JumpBranch <= 3'd0;
    end else if (!ext_stall) begin
      if (hz) begin
        EX_rsAddr     <= 5'd0;
        EX_rtAddr     <= 5'd0;
        EX_wrAddr     <= 5'd0;
        EX_RegWrite   <= 1'b0;
        EX_MemWrite   <= 1'b0;
        EX_MemtoReg   <= 1'b0;
        EX_JumpBranch <= 3'd0;
      end else begin
        EX_rsAddr     <= id.ID_rsAddr;
        EX_rtAddr     <= id.ID_rtAddr;
        EX_wrAddr     <= id.ID_wrAddr;
        EX_RegWrite   <= id.ID_RegWrite;
        EX_MemWrite   <= id.ID_MemWrite;
        EX_MemtoReg   <= id.ID_MemtoReg;
        EX_JumpBranch <= id.ID_JumpBranch;
      end
    end
  end

  // EX/MEM and MEM/WB stages: advance every cycle except under ext_stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MEM_rtAddr     <= 5'd0;
      MEM_wrAddr     <= 5'd0;
      MEM_RegWrite   <= 1'b0;
      MEM_MemWrite   <= 1'b0;
      MEM_MemtoReg   <= 1'b0;
      MEM_JumpBranch <= 3'd0;
      WB_wrAddr      <= 5'd0;
      WB_RegWrite    <= 1'b0;
      WB_MemtoReg    <= 1'b0;
    end else if (!ext_stall) begin
      MEM_rtAddr     <= EX_rtAddr;
      MEM_wrAddr     <= EX_wrAddr;
      MEM_RegWrite   <= EX_RegWrite;
      MEM_MemWrite   <= EX_MemWrite;
      MEM_MemtoReg   <= EX_MemtoReg;
      MEM_JumpBranch <= EX_JumpBranch;
      WB_wrAddr      <= MEM_wrAddr;
      WB_RegWrite    <= MEM_RegWrite;
      WB_MemtoReg    <= MEM_MemtoReg;
    end
  end

  // Saturating event counters for hazard stalls and taken-branch flushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (IDEX_Bubble && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (IFID_Flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
